// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types plus the state and port encodings used by the
// memory arbiter that fronts the unified physical memory.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } lc3b_arb_state;

   typedef enum logic {
      IMEM,
      DMEM
   } lc3b_arb_port;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises the split instruction/data ports onto one physical memory port,
// one transaction at a time, and returns a one-cycle resp with registered data.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter bit FAIR       = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  imem_read,
   input  logic [ADDR_WIDTH-1:0] imem_address,
   output logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  imem_resp,

   input  logic                  dmem_read,
   input  logic                  dmem_write,
   input  lc3b_mem_wmask         dmem_wmask,
   input  logic [ADDR_WIDTH-1:0] dmem_address,
   input  logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  dmem_resp,

   output logic                  pmem_read,
   output logic                  pmem_write,
   output lc3b_mem_wmask         pmem_wmask,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [DATA_WIDTH-1:0] pmem_wdata,
   input  logic [DATA_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   lc3b_arb_state         state_q,      state_d;
   lc3b_arb_port          grant_q,      grant_d;
   lc3b_arb_port          last_grant_q, last_grant_d;
   logic                  write_q,      write_d;
   logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
   lc3b_mem_wmask         wmask_q,      wmask_d;
   logic [DATA_WIDTH-1:0] imem_rdata_q, imem_rdata_d;
   logic [DATA_WIDTH-1:0] dmem_rdata_q, dmem_rdata_d;

   logic imem_req;
   logic dmem_req;
   logic in_access;

   assign imem_req  = imem_read;
   assign dmem_req  = dmem_read | dmem_write;
   assign in_access = (state_q == ACCESS);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= IMEM;
         last_grant_q <= IMEM;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         imem_rdata_q <= '0;
         dmem_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         imem_rdata_q <= imem_rdata_d;
         dmem_rdata_q <= dmem_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      write_d      = write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      imem_rdata_d = imem_rdata_q;
      dmem_rdata_d = dmem_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (imem_req || dmem_req) begin
               if (imem_req && dmem_req) begin
                  if (FAIR) begin
                     grant_d = (last_grant_q == IMEM) ? DMEM : IMEM;
                  end else begin
                     grant_d = DMEM;
                  end
               end else begin
                  grant_d = dmem_req ? DMEM : IMEM;
               end
               last_grant_d = grant_d;
               state_d      = ACCESS;
               // Read+write together on the data port is resolved as a store.
               if (grant_d == DMEM) begin
                  write_d = dmem_write;
                  addr_d  = dmem_address;
                  wdata_d = dmem_wdata;
                  wmask_d = dmem_wmask;
               end else begin
                  write_d = 1'b0;
                  addr_d  = imem_address;
                  wdata_d = '0;
                  wmask_d = 2'b11;
               end
            end
         end
         ACCESS: begin
            if (pmem_resp) begin
               state_d = RESP;
               if (!write_q) begin
                  if (grant_q == IMEM) begin
                     imem_rdata_d = pmem_rdata;
                  end else begin
                     dmem_rdata_d = pmem_rdata;
                  end
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Physical bus is only driven while a transaction is in flight.
   assign pmem_read    = in_access && !write_q;
   assign pmem_write   = in_access && write_q;
   assign pmem_address = in_access ? addr_q  : '0;
   assign pmem_wdata   = in_access ? wdata_q : '0;
   assign pmem_wmask   = in_access ? wmask_q : 2'b00;

   assign imem_resp  = (state_q == RESP) && (grant_q == IMEM);
   assign dmem_resp  = (state_q == RESP) && (grant_q == DMEM);
   assign imem_rdata = imem_rdata_q;
   assign dmem_rdata = dmem_rdata_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the pipelined LC-3b datapath's split instruction and data ports.
- Accepts the fetch-stage request (imem_*) and the MEM-stage request (dmem_*) and serialises them onto one unified physical memory port (pmem_*).
- Returns a one-cycle resp pulse with registered read data to the requesting port.
- Sits between the datapath and the unified memory/L2 model, one instance per core.

Parameters:
- ADDR_WIDTH, 16, width of all address buses.
- DATA_WIDTH, 16, width of all data buses.
- FAIR, 1, conflict policy. 1 = alternate grants on simultaneous requests; 0 = dmem always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_read  in  1  instruction fetch request, held until imem_resp.
- imem_address  in  ADDR_WIDTH  fetch address.
- imem_rdata  out  DATA_WIDTH  fetched word, valid while imem_resp=1.
- imem_resp  out  1  one-cycle completion pulse for imem.
- dmem_read  in  1  data load request, held until dmem_resp.
- dmem_write  in  1  data store request, held until dmem_resp.
- dmem_wmask  in  2  byte enables for stores (lc3b_mem_wmask).
- dmem_address  in  ADDR_WIDTH  data address.
- dmem_wdata  in  DATA_WIDTH  store data.
- dmem_rdata  out  DATA_WIDTH  load data, valid while dmem_resp=1.
- dmem_resp  out  1  one-cycle completion pulse for dmem.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_wmask  out  2  physical byte enables.
- pmem_address  out  ADDR_WIDTH  physical address.
- pmem_wdata  out  DATA_WIDTH  physical write data.
- pmem_rdata  in  DATA_WIDTH  physical read data, valid with pmem_resp.
- pmem_resp  in  1  physical completion, one cycle.

Behaviour:
- Reset (reset=0): immediately, asynchronously:
  - state=IDLE, last_grant=IMEM.
  - All outputs 0, including imem_rdata, dmem_rdata and pmem_wmask.
- IDLE, grant selection:
  - Only imem_read pending -> grant IMEM.
  - Only dmem_read or dmem_write pending -> grant DMEM.
  - Both pending, FAIR=1 -> grant the port not in last_grant.
  - Both pending, FAIR=0 -> grant DMEM.
  - No request -> stay IDLE.
  - On grant: register address, wdata, wmask and op; go to ACCESS; update last_grant.
- dmem_read and dmem_write both high: treated as a write. dmem_rdata is not updated.
- IMEM grants: pmem_wmask=2'b11, read only.
- ACCESS:
  - pmem_read or pmem_write is asserted with the latched address/data, stable for the whole state.
  - On pmem_resp=1: capture pmem_rdata (reads only), go to RESP.
  - There is no timeout.
- RESP (one cycle):
  - pmem strobes are 0.
  - The granted port's resp=1 and its rdata holds the captured word.
  - Next state IDLE.
- The requester may present a new request in the cycle after its resp. It is re-arbitrated in IDLE.
- Latency:
  - Request high at IDLE cycle 0 -> strobe from cycle 1.
  - pmem_resp at cycle 1+k (k>=0) -> port resp at cycle 2+k.
  - Minimum request-to-resp is 2 cycles; 3 cycles request-to-next-grant.
- Writes: dmem_resp pulses in RESP; dmem_rdata keeps its previous value.
- imem_rdata/dmem_rdata hold their last captured value outside resp.
- Request dropped during ACCESS (requester protocol violation): the transaction still completes and resp still pulses. Nothing is cancelled.
- A pmem_resp arriving in IDLE or RESP is ignored.
- At most one pmem transaction is outstanding; never both strobes at once.

Decomposition:
- Add to package lc3b_types:
  - enum lc3b_arb_state {IDLE, ACCESS, RESP}.
  - enum lc3b_arb_port {IMEM, DMEM}.
- Reuse existing lc3b_word and lc3b_mem_wmask.
- Single module with one FSM plus capture registers. No sub-module is warranted.

Test Plan:
- imem_read=1, addr 16'h0040, memory latency k=3, data 16'h1234 -> pmem_read high cycles 1-4; imem_resp=1 and imem_rdata=16'h1234 at cycle 5 only; dmem_resp stays 0.
- dmem_write=1, addr 16'h0081, wdata 16'hAB00, wmask 2'b10, k=0 -> pmem_write cycle 1 with addr 16'h0081 and mask 2'b10; dmem_resp at cycle 2; dmem_rdata unchanged.
- FAIR=1, imem and dmem both held continuously, k=1 -> grants alternate DMEM, IMEM, DMEM, IMEM (last_grant=IMEM after reset); no port waits more than one transaction.
- FAIR=0, same stimulus -> only DMEM granted while dmem held; imem is served in the first IDLE after dmem drops.
- reset driven low mid-ACCESS (pmem_read high) -> pmem_read and every resp fall the same cycle with no clock edge; after release, state is IDLE and the pending imem request is re-granted.
- dmem_read=dmem_write=1 -> pmem_write only, pmem_read never asserted; a stray pmem_resp in IDLE produces no resp.
